// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: in-order decode/dispatch with a circular ROB tag pool, local jumps and optional branch serialisation.
// Ports: clock/reset (async active-low); IFQ side (ifetch_*, dispatch_ren, dispatch_jmp*);
// issue queue side (issueque_*_full, dispatch_en_*, dispatch_* fields); retire_valid, cdb_branch_*, flush.
module dispatch_ctrl #(
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 5,
    parameter int ROB_DEPTH    = 32,
    parameter int BRANCH_STALL = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] ifetch_pc_4,
    input  logic [31:0]       ifetch_instruction,
    input  logic              ifetch_empty,
    output logic              dispatch_ren,
    output logic              dispatch_jmp,
    output logic [DATA_W-1:0] dispatch_jmp_addr,
    input  logic              issueque_integer_full,
    input  logic              issueque_ld_st_full,
    input  logic              issueque_mul_full,
    output logic              dispatch_en_integer,
    output logic              dispatch_en_ld_st,
    output logic              dispatch_en_mul,
    output logic [4:0]        dispatch_rs_reg,
    output logic [4:0]        dispatch_rt_reg,
    output logic [4:0]        dispatch_rd_reg,
    output logic [TAG_W-1:0]  dispatch_rd_tag,
    output logic [2:0]        dispatch_opcode,
    output logic [4:0]        dispatch_shfamt,
    output logic [15:0]       dispatch_imm,
    output logic              dispatch_branch,
    output logic [DATA_W-1:0] dispatch_pc,
    input  logic              retire_valid,
    input  logic              cdb_branch_valid,
    input  logic [TAG_W-1:0]  cdb_branch_tag,
    input  logic              flush
);
    localparam int CW = $clog2(ROB_DEPTH + 1);

    typedef enum logic [1:0] {RUN, REDIRECT, BR_WAIT} state_t;

    state_t           state_q;
    logic [TAG_W-1:0] head_q, head_d, br_tag_q;
    logic [CW-1:0]    count_q, count_d;
    logic [5:0]       op, fn;
    logic             is_r, is_mul, is_int, is_ls, is_sw, is_br, is_j, is_q;
    logic             full, ret, room, alloc, jump;
    logic [2:0]       alu_op, opcode_d;

    assign op     = ifetch_instruction[31:26];
    assign fn     = ifetch_instruction[5:0];
    assign is_r   = op == 6'b000000;
    assign is_mul = is_r && fn == 6'b011000;
    assign is_br  = op == 6'b000100 || op == 6'b000101;
    assign is_int = (is_r && !is_mul) || op == 6'b001000 || is_br;
    assign is_sw  = op == 6'b101011;
    assign is_ls  = op == 6'b100011 || is_sw;
    assign is_j   = op == 6'b000010;
    assign is_q   = is_int || is_ls || is_mul;

    always_comb begin
        alu_op = fn == 6'b100000 ? 3'd0 : fn == 6'b100010 ? 3'd1 : fn == 6'b100100 ? 3'd2 :
                 fn == 6'b100101 ? 3'd3 : fn == 6'b101010 ? 3'd4 : fn == 6'b000000 ? 3'd5 :
                 fn == 6'b000010 ? 3'd6 : 3'd7;
        opcode_d = is_r ? alu_op : (is_br || is_sw) ? 3'd1 : 3'd0;
    end

    assign full = is_mul ? issueque_mul_full : is_ls ? issueque_ld_st_full : issueque_integer_full;
    // A retirement in the same cycle frees a slot, so a full pool can still allocate.
    assign ret  = retire_valid && count_q != '0;
    assign room = count_q < CW'(ROB_DEPTH) || ret;

    assign dispatch_ren = state_q == RUN && !ifetch_empty && !flush && (!is_q || (!full && room));
    assign alloc        = dispatch_ren && is_q;
    assign jump         = dispatch_ren && is_j;

    assign count_d = flush ? '0 : count_q + CW'(alloc) - CW'(ret);
    assign head_d  = !alloc ? head_q : head_q == TAG_W'(ROB_DEPTH - 1) ? '0 : head_q + TAG_W'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q             <= RUN;
            head_q              <= '0;
            count_q             <= '0;
            br_tag_q            <= '0;
            dispatch_jmp        <= 1'b0;
            dispatch_jmp_addr   <= '0;
            dispatch_en_integer <= 1'b0;
            dispatch_en_ld_st   <= 1'b0;
            dispatch_en_mul     <= 1'b0;
            dispatch_rs_reg     <= '0;
            dispatch_rt_reg     <= '0;
            dispatch_rd_reg     <= '0;
            dispatch_rd_tag     <= '0;
            dispatch_opcode     <= '0;
            dispatch_shfamt     <= '0;
            dispatch_imm        <= '0;
            dispatch_branch     <= 1'b0;
            dispatch_pc         <= '0;
        end else begin
            head_q              <= head_d;
            count_q             <= count_d;
            dispatch_jmp        <= jump;
            dispatch_en_integer <= alloc && is_int;
            dispatch_en_ld_st   <= alloc && is_ls;
            dispatch_en_mul     <= alloc && is_mul;
            if (jump)
                dispatch_jmp_addr <= {ifetch_pc_4[DATA_W-1:28], ifetch_instruction[25:0], 2'b00};
            if (alloc) begin
                dispatch_rs_reg <= ifetch_instruction[25:21];
                dispatch_rt_reg <= ifetch_instruction[20:16];
                dispatch_rd_reg <= is_r ? ifetch_instruction[15:11] : ifetch_instruction[20:16];
                dispatch_rd_tag <= head_q;
                dispatch_opcode <= opcode_d;
                dispatch_shfamt <= ifetch_instruction[10:6];
                dispatch_imm    <= ifetch_instruction[15:0];
                dispatch_branch <= is_br;
                dispatch_pc     <= ifetch_pc_4;
            end
            if (flush)
                state_q <= RUN;
            else if (jump)
                state_q <= REDIRECT;
            else if (alloc && is_br && BRANCH_STALL != 0) begin
                state_q  <= BR_WAIT;
                br_tag_q <= head_q;
            end else if (state_q == REDIRECT || (state_q == BR_WAIT && cdb_branch_valid && cdb_branch_tag == br_tag_q))
                state_q <= RUN;
        end
    end
endmodule
